// File: rtl/io_write_port_arbiter_if.sv
// Bus bundle between the CPU write path / external consumer and the write port arbiter.
interface io_write_port_arbiter_if #(
    parameter int unsigned WORD_WIDTH      = 36,
    parameter int unsigned ADDR_WIDTH      = 10,
    parameter int unsigned PORT_COUNT      = 4,
    parameter int unsigned PORT_ADDR_WIDTH = 2
);
    logic                       cpu_wren;
    logic [ADDR_WIDTH-1:0]      cpu_addr;
    logic [WORD_WIDTH-1:0]      cpu_data;
    logic [PORT_COUNT-1:0]      port_EF;
    logic                       out_valid;
    logic                       out_ready;
    logic [WORD_WIDTH-1:0]      out_data;
    logic [PORT_ADDR_WIDTH-1:0] out_port;
    logic                       overrun;

    // CPU writer and output consumer side
    modport master (
        output cpu_wren, cpu_addr, cpu_data, out_ready,
        input  port_EF, out_valid, out_data, out_port, overrun
    );

    // Arbiter side
    modport slave (
        input  cpu_wren, cpu_addr, cpu_data, out_ready,
        output port_EF, out_valid, out_data, out_port, overrun
    );
endinterface

// File: rtl/io_write_port_arbiter.sv
// One-word I/O write ports with E/F bits, drained round-robin into a registered valid/ready stage.
module io_write_port_arbiter #(
    parameter int unsigned WORD_WIDTH      = 36,
    parameter int unsigned ADDR_WIDTH      = 10,
    parameter int unsigned PORT_COUNT      = 4,
    parameter int unsigned PORT_BASE_ADDR  = 0,
    parameter int unsigned PORT_ADDR_WIDTH = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    io_write_port_arbiter_if.slave bus
);
    localparam int unsigned EXT_W = ADDR_WIDTH + 1;
    localparam int unsigned POS_W = PORT_ADDR_WIDTH + 1;
    localparam logic [EXT_W-1:0]           BASE_EXT  = EXT_W'(PORT_BASE_ADDR);
    localparam logic [EXT_W-1:0]           COUNT_EXT = EXT_W'(PORT_COUNT);
    localparam logic [POS_W-1:0]           COUNT_POS = POS_W'(PORT_COUNT);
    localparam logic [PORT_ADDR_WIDTH-1:0] LAST_PORT = PORT_ADDR_WIDTH'(PORT_COUNT - 1);

    logic [WORD_WIDTH-1:0]      slot_q [PORT_COUNT];
    logic [PORT_COUNT-1:0]      ef_q, ef_d;
    logic                       out_valid_q, out_valid_d;
    logic [WORD_WIDTH-1:0]      out_data_q, out_data_d;
    logic [PORT_ADDR_WIDTH-1:0] out_port_q, out_port_d;
    logic                       overrun_q, overrun_d;
    logic [PORT_ADDR_WIDTH-1:0] rr_ptr_q, rr_ptr_d;

    logic [EXT_W-1:0]           addr_ext;
    logic [EXT_W-1:0]           addr_off;
    logic                       wr_hit;
    logic [PORT_ADDR_WIDTH-1:0] wr_idx;
    logic                       wr_accept;
    logic                       load_en;
    logic                       gnt_vld;
    logic [PORT_ADDR_WIDTH-1:0] gnt_idx;
    logic [POS_W-1:0]           pos;

    // Address decode: in-range writes only, unsigned compare avoids wrap-around aliasing
    always_comb begin
        addr_ext = {1'b0, bus.cpu_addr};
        addr_off = addr_ext - BASE_EXT;
        wr_hit   = bus.cpu_wren && (addr_ext >= BASE_EXT) && (addr_off < COUNT_EXT);
        wr_idx   = PORT_ADDR_WIDTH'(addr_off);
    end

    // Round-robin search for the first full port at or above rr_ptr, wrapping
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = rr_ptr_q;
        pos     = '0;
        for (int unsigned k = 0; k < PORT_COUNT; k++) begin
            pos = {1'b0, rr_ptr_q} + POS_W'(k);
            if (pos >= COUNT_POS) begin
                pos = pos - COUNT_POS;
            end
            if (!gnt_vld && ef_q[pos[PORT_ADDR_WIDTH-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = pos[PORT_ADDR_WIDTH-1:0];
            end
        end
    end

    // Next state: output load, E/F update, write acceptance and overrun
    always_comb begin
        ef_d        = ef_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_port_d  = out_port_q;
        overrun_d   = overrun_q;
        rr_ptr_d    = rr_ptr_q;
        wr_accept   = 1'b0;
        load_en     = !out_valid_q || bus.out_ready;

        if (load_en && gnt_vld) begin
            out_valid_d   = 1'b1;
            out_data_d    = slot_q[gnt_idx];
            out_port_d    = gnt_idx;
            ef_d[gnt_idx] = 1'b0;
            rr_ptr_d      = (gnt_idx == LAST_PORT) ? '0 : gnt_idx + PORT_ADDR_WIDTH'(1);
        end else if (load_en) begin
            out_valid_d = 1'b0;
        end

        // A port being granted this cycle counts as empty for the incoming write
        if (wr_hit) begin
            if (!ef_d[wr_idx]) begin
                wr_accept    = 1'b1;
                ef_d[wr_idx] = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // Control and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            ef_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_port_q  <= '0;
            overrun_q   <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            ef_q        <= ef_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_port_q  <= out_port_d;
            overrun_q   <= overrun_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    // Slot storage; contents are meaningless while the E/F bit is clear
    always_ff @(posedge clock) begin
        if (!reset && wr_accept) begin
            slot_q[wr_idx] <= bus.cpu_data;
        end
    end

    assign bus.port_EF   = ef_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_port  = out_port_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_io_write_port_arbiter.sv
// Bench for io_write_port_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_io_write_port_arbiter;
    localparam int unsigned WW   = 36;
    localparam int unsigned AW   = 10;
    localparam int unsigned PC   = 4;
    localparam int unsigned BASE = 8;
    localparam int unsigned PAW  = 2;

    logic clock;
    logic reset;

    io_write_port_arbiter_if #(
        .WORD_WIDTH(WW), .ADDR_WIDTH(AW), .PORT_COUNT(PC), .PORT_ADDR_WIDTH(PAW)
    ) bus ();

    io_write_port_arbiter #(
        .WORD_WIDTH(WW), .ADDR_WIDTH(AW), .PORT_COUNT(PC),
        .PORT_BASE_ADDR(BASE), .PORT_ADDR_WIDTH(PAW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model state
    bit [WW-1:0] m_slot [PC];
    bit          m_full [PC];
    bit          m_valid;
    bit [WW-1:0] m_data;
    int          m_port;
    bit          m_over;
    int          m_rr;
    bit          m_init = 0;

    bit          m_load, m_gnt;
    int          m_g, m_j, m_idx;
    logic [PC-1:0] m_ef;

    // Model advances on every rising edge, then DUT outputs are compared 1ns later
    always @(posedge clock) begin
        if (reset) begin
            m_init = 1;
            for (int i = 0; i < PC; i++) m_full[i] = 0;
            m_valid = 0; m_data = '0; m_port = 0; m_over = 0; m_rr = 0;
        end else if (m_init) begin
            m_load = !m_valid || bus.out_ready;
            m_gnt  = 0;
            m_g    = 0;
            for (int k = 0; k < PC; k++) begin
                m_j = (m_rr + k) % PC;
                if (!m_gnt && m_full[m_j]) begin
                    m_gnt = 1;
                    m_g   = m_j;
                end
            end
            if (m_load && m_gnt) begin
                m_valid     = 1;
                m_data      = m_slot[m_g];
                m_port      = m_g;
                m_full[m_g] = 0;
                m_rr        = (m_g + 1) % PC;
            end else if (m_load) begin
                m_valid = 0;
            end
            m_idx = int'(bus.cpu_addr) - int'(BASE);
            if (bus.cpu_wren && m_idx >= 0 && m_idx < int'(PC)) begin
                if (!m_full[m_idx]) begin
                    m_slot[m_idx] = bus.cpu_data;
                    m_full[m_idx] = 1;
                end else begin
                    m_over = 1;
                end
            end
        end
        #1;
        if (m_init) begin
            for (int i = 0; i < PC; i++) m_ef[i] = m_full[i];
            chk("model_port_EF", 64'(bus.port_EF), 64'(m_ef));
            chk("model_out_valid", 64'(bus.out_valid), 64'(m_valid));
            chk("model_out_data", 64'(bus.out_data), 64'(m_data));
            chk("model_out_port", 64'(bus.out_port), 64'(m_port));
            chk("model_overrun", 64'(bus.overrun), 64'(m_over));
        end
    end

    // Advance one cycle; inputs are changed 2ns after the rising edge
    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    task automatic wr(input int port, input logic [WW-1:0] data);
        bus.cpu_wren = 1'b1;
        bus.cpu_addr = AW'(BASE + port);
        bus.cpu_data = data;
        cyc();
        bus.cpu_wren = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.cpu_wren = 1'b1;
        bus.cpu_addr = AW'(BASE + 1);
        bus.cpu_data = 36'($urandom);
        bus.out_ready = 1'(($urandom));
        cyc();
        cyc();
        reset = 1'b0;
        bus.cpu_wren = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.cpu_wren  = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_data  = '0;
        bus.out_ready = 1'b0;

        // Reset with a write strobe active
        do_reset();
        chk("rst_port_EF", 64'(bus.port_EF), 64'h0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
        chk("rst_out_data", 64'(bus.out_data), 64'h0);
        chk("rst_out_port", 64'(bus.out_port), 64'h0);
        chk("rst_overrun", 64'(bus.overrun), 64'h0);

        // Single word through port 2
        bus.out_ready = 1'b1;
        wr(2, 36'h0ABC);
        chk("single_ef_n1", 64'(bus.port_EF), 64'h4);
        chk("single_valid_n1", 64'(bus.out_valid), 64'h0);
        cyc();
        chk("single_valid_n2", 64'(bus.out_valid), 64'h1);
        chk("single_data_n2", 64'(bus.out_data), 64'h0ABC);
        chk("single_port_n2", 64'(bus.out_port), 64'h2);
        chk("single_ef_n2", 64'(bus.port_EF), 64'h0);
        cyc();
        chk("single_valid_n3", 64'(bus.out_valid), 64'h0);

        // Round-robin order: fill all four under backpressure, then release
        do_reset();
        bus.out_ready = 1'b0;
        for (int p = 0; p < 4; p++) wr(p, WW'(36'h10 + p));
        chk("rr_hold_data", 64'(bus.out_data), 64'h10);
        bus.out_ready = 1'b1;
        for (int p = 1; p < 4; p++) begin
            cyc();
            chk("rr_seq_data", 64'(bus.out_data), 64'(36'h10 + p));
            chk("rr_seq_port", 64'(bus.out_port), 64'(p));
        end
        cyc();
        chk("rr_drained", 64'(bus.out_valid), 64'h0);

        // Wrap: after a port-1 grant, port 3 precedes port 0
        wr(1, 36'h21);
        cyc();
        chk("wrap_p1", 64'(bus.out_data), 64'h21);
        bus.out_ready = 1'b0;
        wr(0, 36'h30);
        wr(3, 36'h33);
        bus.out_ready = 1'b1;
        cyc();
        chk("wrap_first", 64'(bus.out_port), 64'h3);
        chk("wrap_first_data", 64'(bus.out_data), 64'h33);
        cyc();
        chk("wrap_second", 64'(bus.out_port), 64'h0);
        chk("wrap_second_data", 64'(bus.out_data), 64'h30);
        cyc();

        // Backpressure stability and overrun
        bus.out_ready = 1'b0;
        wr(0, 36'h40);
        wr(1, 36'h41);
        wr(1, 36'h99);
        for (int i = 0; i < 10; i++) begin
            chk("bp_stable_data", 64'(bus.out_data), 64'h40);
            chk("bp_stable_valid", 64'(bus.out_valid), 64'h1);
            cyc();
        end
        chk("ovr_set", 64'(bus.overrun), 64'h1);
        bus.out_ready = 1'b1;
        cyc();
        chk("ovr_slot_kept", 64'(bus.out_data), 64'h41);
        cyc();
        chk("ovr_drained", 64'(bus.out_valid), 64'h0);
        chk("ovr_sticky", 64'(bus.overrun), 64'h1);

        // Write to port 0 in the same cycle it is granted
        do_reset();
        chk("ovr_cleared", 64'(bus.overrun), 64'h0);
        bus.out_ready = 1'b1;
        wr(0, 36'h5);
        wr(0, 36'h6);
        chk("simul_data", 64'(bus.out_data), 64'h5);
        chk("simul_ef", 64'(bus.port_EF), 64'h1);
        chk("simul_ovr", 64'(bus.overrun), 64'h0);
        cyc();
        chk("simul_next", 64'(bus.out_data), 64'h6);
        chk("simul_valid", 64'(bus.out_valid), 64'h1);
        cyc();

        // Decode boundaries around base address 8
        bus.cpu_wren = 1'b1; bus.cpu_addr = AW'(7); bus.cpu_data = 36'h77;
        cyc();
        chk("dec_addr7", 64'(bus.port_EF), 64'h0);
        bus.cpu_addr = AW'(12);
        cyc();
        chk("dec_addr12", 64'(bus.port_EF), 64'h0);
        bus.cpu_addr = AW'(11);
        cyc();
        bus.cpu_wren = 1'b0;
        chk("dec_addr11", 64'(bus.port_EF), 64'h8);
        cyc();
        cyc();

        // Randomized traffic checked against the model every cycle
        for (int i = 0; i < 3000; i++) begin
            reset         = ($urandom_range(0, 299) == 0);
            bus.cpu_wren  = ($urandom_range(0, 99) < 60);
            bus.cpu_addr  = AW'($urandom_range(6, 13));
            bus.cpu_data  = WW'({$urandom, $urandom});
            bus.out_ready = ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 70 : 25));
            cyc();
        end
        reset = 1'b0;
        bus.cpu_wren = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/io_write_port_arbiter.md
# io_write_port_arbiter

Controller for a bank of `PORT_COUNT` one-word I/O write ports that share a single external output channel. It holds each CPU-written word and drives the per-port Empty/Full bits that the pipeline's E/F selection logic uses to annul writes to full ports. It drains full ports round-robin into one registered valid/ready output stage. It sits between the CPU write path and the external consumer.

## Interface
Parameters:
- `WORD_WIDTH`, 36, data word width.
- `ADDR_WIDTH`, 10, CPU write address width.
- `PORT_COUNT`, 4, number of write ports (≥2).
- `PORT_BASE_ADDR`, 0, CPU address of port 0.
- `PORT_ADDR_WIDTH`, 2, port index width (≥ clog2(`PORT_COUNT`)).

Ports:
- `clock`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous reset, active-high.
- `cpu_wren`  in  1  CPU write strobe.
- `cpu_addr`  in  `ADDR_WIDTH`  CPU write address.
- `cpu_data`  in  `WORD_WIDTH`  CPU write data.
- `port_EF`  out  `PORT_COUNT`  per-port full bit (1 = full, 0 = empty); registered.
- `out_valid`  out  1  output word valid.
- `out_ready`  in  1  consumer accepts the word.
- `out_data`  out  `WORD_WIDTH`  output word.
- `out_port`  out  `PORT_ADDR_WIDTH`  index of the port the word came from.
- `overrun`  out  1  sticky flag: a write hit a full port; cleared only by `reset`.

## Operation
- **Address decode:** idx = `cpu_addr` − `PORT_BASE_ADDR`. A write is valid when `cpu_wren`=1 and 0 ≤ idx < `PORT_COUNT`; all other writes are ignored with no side effects.
- **Valid write, port idx empty:** slot[idx] ← `cpu_data`; `port_EF[idx]` ← 1.
- **Valid write, port idx full and not granted this cycle:**
  - Write is dropped; the slot keeps its old word.
  - `overrun` ← 1. Upstream annulment normally prevents this case.
- **Output stage:** one register holding (`out_valid`, `out_data`, `out_port`). A transfer occurs when `out_valid` & `out_ready`.
- **Load enable:** the output register may load when `out_valid`=0 or a transfer occurs this cycle.
- **Arbitration:** when load is enabled and any `port_EF` bit is 1:
  - Grant the first full port found searching upward from `rr_ptr`, wrapping past `PORT_COUNT`−1 to 0.
  - The granted slot moves into the output register, `out_valid` ← 1, and `port_EF[grant]` ← 0.
  - `rr_ptr` ← grant+1, wrapping to 0.
- **No grant:** if load is enabled and no port is full, a transfer clears `out_valid` to 0.
- **Write to the granted port in the same cycle:**
  - The new word is accepted into the slot and `port_EF` stays 1.
  - The old word goes to the output register.
  - `overrun` is not set.
- **Backpressure:** while `out_valid`=1 and `out_ready`=0:
  - `out_data`/`out_port` stay stable; there is no grant.
  - `rr_ptr` holds; slots keep filling until full.
- **Reset values:** `port_EF`=0, `out_valid`=0, `out_data`=0, `out_port`=0, `overrun`=0, `rr_ptr`=0. Slot contents are don't-care.
  - A reset asserted mid-operation discards all held and in-flight words.
  - Any CPU write in the reset cycle is ignored.

## Timing
- CPU write in cycle N → `port_EF[idx]`=1 in N+1.
- Earliest `out_valid` for that word is N+2; there is no bypass from the CPU to the output.
- Grant in cycle M → `port_EF[grant]`=0 and the output register loaded in M+1.
- With `out_ready` held 1, sustained throughput is one word per cycle.
- `out_valid` never deasserts without a transfer.
- `port_EF` is registered only; there is no combinational path from `cpu_*` to `port_EF` or the out_* outputs.
- The only combinational input→output path is `out_ready` → load enable, which is internal; outputs stay registered.

## Test plan
- **Reset:** assert `reset` 2 cycles with random inputs → all outputs 0; `cpu_wren` in the reset cycle leaves `port_EF`=0.
- **Single word:** `out_ready`=1; write 0x0ABC to port 2 at cycle N → `port_EF`=0100 at N+1; `out_valid`=1, `out_data`=0x0ABC, `out_port`=2 at N+2; `port_EF`=0000 at N+2.
- **Round-robin and wrap:**
  - `out_ready`=0; fill ports 0–3 with 0x10–0x13; then `out_ready`=1 → words emerge 0x10, 0x11, 0x12, 0x13 on consecutive cycles.
  - Next, drain a port-1 word (`rr_ptr`=2), then fill ports 0 and 3 → port 3 emerges before port 0.
- **Backpressure and overrun:**
  - `out_ready`=0 with `out_valid`=1 → `out_data` stable for 10 cycles.
  - A write to full port 1 → slot unchanged and `overrun`=1, which persists after draining until `reset`.
- **Simultaneous write and grant:** port 0 holds 0x5 and is granted in the same cycle a write of 0x6 to port 0 occurs → 0x5 is output, `port_EF[0]` stays 1, 0x6 is output next, `overrun`=0.
- **Decode boundaries:** with `PORT_BASE_ADDR`=8, a write to address 7 or 12 → ignored; a write to address 11 → `port_EF[3]`=1.
